// File: rtl/cu_pkg.sv
// Shared CU types and constants for the fetch front end.
package cu_pkg;
  localparam int CU_XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic MEM_READ = 1'b0;

  typedef struct packed {
    logic [CU_XLEN-1:0] pc;
    logic [CU_XLEN-1:0] instr;
    logic               fault;
  } fetch_entry_t;

  function automatic logic [CU_XLEN-1:0] word_align(input logic [CU_XLEN-1:0] a);
    return {a[CU_XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/cu_if_fetch_if.sv
// Fetch <-> MMU read channel: valid/ready request, in-order response.
interface cu_if_fetch_if #(parameter int XLEN = 32);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic [3:0]      mem_req_bits_to_access;
  logic            mem_req_read_or_write;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_bits_to_access, mem_req_read_or_write,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_bits_to_access, mem_req_read_or_write,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );
endinterface

// File: rtl/cu_if_fifo.sv
// First-word-fall-through prefetch FIFO of fetch entries; flush wins over push/pop.
module cu_if_fifo
  import cu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output logic         full_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  // Storage carries no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge gclk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/cu_if_fetch.sv
// Instruction-fetch front end: PC/credit-based MMU read issue, stale-response discard
// after redirect, and a prefetch FIFO of PC-tagged instructions feeding decode.
module cu_if_fetch
  import cu_pkg::*;
#(
  parameter int              XLEN       = CU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            soc_clk,
  input  logic            IF_reset_n,
  input  logic            IF_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  cu_if_fetch_if.master   mem,
  output logic            IF_valid,
  output logic [XLEN-1:0] IF_data,
  output logic [XLEN-1:0] IF_pc,
  output logic            IF_fault
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d;
  logic            init_q;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_empty, fifo_full;
  logic [CW:0]     inflight, redir_sum;
  logic            req_fire, rsp_drop, rsp_take, fifo_pop;
  fetch_entry_t    push_ent, head;

  // Every issued request owns a slot until it is popped or discarded, so the
  // FIFO can never overflow regardless of how long decode stalls.
  assign inflight = {1'b0, out_q} + {1'b0, drop_q} + {1'b0, fifo_cnt};

  assign mem.mem_req_valid          = init_q && !redirect_valid && (inflight < (CW+1)'(FIFO_DEPTH));
  assign mem.mem_req_addr           = pc_q;
  assign mem.mem_req_bits_to_access = BE_WORD;
  assign mem.mem_req_read_or_write  = MEM_READ;

  assign req_fire = mem.mem_req_valid && mem.mem_req_ready;
  assign rsp_drop = mem.mem_rsp_valid && (drop_q != '0);
  assign rsp_take = mem.mem_rsp_valid && (drop_q == '0) && (out_q != '0) && !redirect_valid;
  assign fifo_pop = IF_valid && !IF_stall && !redirect_valid;

  assign push_ent.pc    = rsp_pc_q;
  assign push_ent.instr = mem.mem_rsp_err ? '0 : mem.mem_rsp_data;
  assign push_ent.fault = mem.mem_rsp_err;

  assign redir_sum = {1'b0, drop_q} + {1'b0, out_q};

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      pc_d     = word_align(redirect_pc);
      rsp_pc_d = word_align(redirect_pc);
      out_d    = '0;
      // Everything still in flight becomes stale; a response landing this cycle is already one of them.
      drop_d   = (mem.mem_rsp_valid && redir_sum != '0) ? CW'(redir_sum - 1'b1) : CW'(redir_sum);
    end else begin
      if (req_fire) pc_d     = pc_q + XLEN'(INSTR_BYTES);
      if (rsp_take) rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
      out_d  = out_q + CW'(req_fire) - CW'(rsp_take);
      drop_d = drop_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge soc_clk or negedge IF_reset_n) begin
    if (!IF_reset_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      init_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      init_q   <= 1'b1;
    end
  end

  cu_if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .gclk    (soc_clk),
    .grst_n  (IF_reset_n),
    .push_i  (rsp_take),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .wdata_i (push_ent),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign IF_valid = !fifo_empty;
  assign IF_pc    = IF_valid ? head.pc    : '0;
  assign IF_data  = IF_valid ? head.instr : '0;
  assign IF_fault = IF_valid && head.fault;

  a_no_orphan_rsp: assert property (@(posedge soc_clk) disable iff (!IF_reset_n)
    !(mem.mem_rsp_valid && out_q == '0 && drop_q == '0));
  a_no_full_push: assert property (@(posedge soc_clk) disable iff (!IF_reset_n)
    !(rsp_take && fifo_full));
  a_credit: assert property (@(posedge soc_clk) disable iff (!IF_reset_n)
    inflight <= (CW+1)'(FIFO_DEPTH));
  a_req_hold: assert property (@(posedge soc_clk) disable iff (!IF_reset_n)
    (mem.mem_req_valid && !mem.mem_req_ready) |=>
      (redirect_valid || (mem.mem_req_valid && $stable(mem.mem_req_addr))));
endmodule

// File: tb/tb_cu_if_fetch.sv
// Scoreboard bench for cu_if_fetch: MMU model with controllable ready/hold, decode stall and redirect.
module tb_cu_if_fetch;
  import cu_pkg::*;
  localparam int XL = 32;
  localparam int DEPTH = 4;

  logic          soc_clk = 1'b0;
  logic          IF_reset_n = 1'b0;
  logic          IF_stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [XL-1:0] redirect_pc = '0;
  logic          IF_valid, IF_fault;
  logic [XL-1:0] IF_data, IF_pc;

  cu_if_fetch_if #(.XLEN(XL)) mem ();

  cu_if_fetch #(.XLEN(XL), .RESET_PC('0), .FIFO_DEPTH(DEPTH)) dut (
    .soc_clk        (soc_clk),
    .IF_reset_n     (IF_reset_n),
    .IF_stall       (IF_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem            (mem.master),
    .IF_valid       (IF_valid),
    .IF_data        (IF_data),
    .IF_pc          (IF_pc),
    .IF_fault       (IF_fault)
  );

  always #5 soc_clk = ~soc_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // MMU model: in-order responses, one cycle after accept unless held.
  logic [31:0] mmu_q[$];
  logic        mmu_hold = 1'b0;
  int          mmu_budget = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  initial begin
    mem.mem_req_ready = 1'b1;
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rsp_data  = '0;
    mem.mem_rsp_err   = 1'b0;
  end

  always @(posedge soc_clk) begin
    #2;
    if (mem.mem_rsp_valid && mmu_q.size() > 0) void'(mmu_q.pop_front());
    if (mmu_q.size() > 0 && (!mmu_hold || mmu_budget > 0)) begin
      if (mmu_hold) mmu_budget--;
      mem.mem_rsp_valid = 1'b1;
      mem.mem_rsp_data  = mdata(mmu_q[0]);
      mem.mem_rsp_err   = (mmu_q[0] == err_addr);
    end else begin
      mem.mem_rsp_valid = 1'b0;
      mem.mem_rsp_data  = '0;
      mem.mem_rsp_err   = 1'b0;
    end
  end

  // Scoreboard / monitor, sampled mid-cycle.
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_pc = '0;
  int           acc_cnt = 0, pop_cnt = 0;
  logic [31:0]  last_pop_pc = '0, prev_addr = '0;
  logic         prev_wait = 1'b0;
  logic         f8_fault, fc_fault;
  logic [31:0]  f8_data;

  always @(negedge soc_clk) begin
    fetch_entry_t e;
    if (!IF_reset_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("req_hold_v", 64'(mem.mem_req_valid || redirect_valid), 1);
        if (!redirect_valid) chk("req_hold_a", 64'(mem.mem_req_addr), 64'(prev_addr));
      end
      prev_wait = mem.mem_req_valid && !mem.mem_req_ready;
      prev_addr = mem.mem_req_addr;
      if (!IF_valid) chk("idle_out", 64'(IF_pc | IF_data | {31'b0, IF_fault}), 0);
      if (redirect_valid) begin
        chk("redir_noreq", 64'(mem.mem_req_valid), 0);
        exp_q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (IF_valid && !IF_stall) begin
          if (exp_q.size() == 0) chk("pop_unexp", 64'(IF_valid), 0);
          else begin
            e = exp_q.pop_front();
            chk("if_pc", 64'(IF_pc), 64'(e.pc));
            chk("if_data", 64'(IF_data), 64'(e.instr));
            chk("if_fault", 64'(IF_fault), 64'(e.fault));
          end
          if (IF_pc == 32'h8) begin f8_fault = IF_fault; f8_data = IF_data; end
          if (IF_pc == 32'hC) fc_fault = IF_fault;
          last_pop_pc = IF_pc;
          pop_cnt++;
        end
        if (mem.mem_req_valid && mem.mem_req_ready) begin
          chk("req_addr", 64'(mem.mem_req_addr), 64'(exp_pc));
          chk("req_attr", 64'({mem.mem_req_bits_to_access, mem.mem_req_read_or_write}), 64'({4'hF, 1'b0}));
          e.pc    = mem.mem_req_addr;
          e.fault = (mem.mem_req_addr == err_addr);
          e.instr = e.fault ? 32'h0 : mdata(mem.mem_req_addr);
          exp_q.push_back(e);
          mmu_q.push_back(mem.mem_req_addr);
          exp_pc = exp_pc + 32'd4;
          acc_cnt++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge soc_clk);
    #1;
  endtask

  task automatic do_reset();
    IF_reset_n = 1'b0;
    redirect_valid = 1'b0;
    mmu_budget = 0;
    exp_q.delete();
    mmu_q.delete();
    exp_pc = '0;
    step(2);
    IF_reset_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int p0 = pop_cnt;
    int c = 0;
    while (pop_cnt - p0 < n && c < budget) begin step(1); c++; end
    chk(tag, 64'(pop_cnt - p0 >= n), 1);
  endtask

  task automatic wait_ifvalid(input int budget, input string tag);
    int c = 0;
    while (!IF_valid && c < budget) begin step(1); c++; end
    chk(tag, 64'(IF_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, p0;
    // reset state
    step(2);
    chk("rst_ifv", 64'(IF_valid), 0);
    chk("rst_reqv", 64'(mem.mem_req_valid), 0);
    chk("rst_ifpc", 64'(IF_pc), 0);
    IF_reset_n = 1'b1;
    #3;
    chk("rel_reqv", 64'(mem.mem_req_valid), 0);
    chk("rel_ifv", 64'(IF_valid), 0);

    // 1: free-running stream
    p0 = pop_cnt;
    step(14);
    chk("t1_flow", 64'(pop_cnt - p0 >= 6), 1);

    // 2: decode stall fills the credit window, release drains 0x0..0xC
    IF_stall = 1'b1;
    do_reset();
    a0 = acc_cnt;
    step(15);
    chk("t2_acc", 64'(acc_cnt - a0), 4);
    chk("t2_reqv", 64'(mem.mem_req_valid), 0);
    chk("t2_ifv", 64'(IF_valid), 1);
    IF_stall = 1'b0;
    wait_pops(4, 20, "t2_drain");
    chk("t2_last", 64'(last_pop_pc), 32'hC);
    wait_pops(1, 20, "t2_resume");
    chk("t2_next", 64'(last_pop_pc), 32'h10);

    // 3: MMU back-pressure holds the address
    mem.mem_req_ready = 1'b0;
    do_reset();
    step(1);
    a0 = acc_cnt;
    step(3);
    chk("t3_v", 64'(mem.mem_req_valid), 1);
    chk("t3_addr", 64'(mem.mem_req_addr), 0);
    chk("t3_noacc", 64'(acc_cnt - a0), 0);
    mem.mem_req_ready = 1'b1;
    step(1);
    chk("t3_acc", 64'(acc_cnt - a0), 1);
    wait_pops(2, 20, "t3_flow");

    // 4: redirect with three requests in flight
    mem.mem_req_ready = 1'b0;
    mmu_hold = 1'b1;
    do_reset();
    step(1);
    a0 = acc_cnt;
    mem.mem_req_ready = 1'b1;
    step(3);
    mem.mem_req_ready = 1'b0;
    chk("t4_acc3", 64'(acc_cnt - a0), 3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    step(1);
    redirect_valid = 1'b0;
    mem.mem_req_ready = 1'b1;
    a0 = acc_cnt;
    step(5);
    chk("t4_credit", 64'(acc_cnt - a0), 1);
    mmu_hold = 1'b0;
    wait_pops(1, 20, "t4_pop");
    chk("t4_first", 64'(last_pop_pc), 32'h100);

    // 5: access fault is buffered, fetch continues
    err_addr = 32'h8;
    f8_fault = 1'b0;
    f8_data = '1;
    fc_fault = 1'b1;
    do_reset();
    wait_pops(5, 30, "t5_flow");
    chk("t5_f8", 64'(f8_fault), 1);
    chk("t5_d8", 64'(f8_data), 0);
    chk("t5_fc", 64'(fc_fault), 0);
    err_addr = 32'hFFFF_FFFF;

    // 6: redirect collides with a response and a would-be pop
    IF_stall = 1'b1;
    mmu_hold = 1'b1;
    do_reset();
    a0 = acc_cnt;
    step(8);
    chk("t6_acc4", 64'(acc_cnt - a0), 4);
    mmu_budget = 1;
    wait_ifvalid(10, "t6_head");
    IF_stall = 1'b0;
    mmu_budget = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    chk("t6_empty", 64'(IF_valid), 0);
    a0 = acc_cnt;
    step(6);
    chk("t6_credit", 64'(acc_cnt - a0), 2);
    chk("t6_reqv", 64'(mem.mem_req_valid), 0);
    mmu_hold = 1'b0;
    wait_pops(2, 20, "t6_pop");
    chk("t6_last", 64'(last_pop_pc), 32'h204);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
